// File: rtl/ecc_scrub_pkg.sv
// Shared types and helpers for the ECC scrub scheduler.
// Holds the FSM state enum and the saturating-increment helper.
package ecc_scrub_pkg;

  typedef enum logic [1:0] {
    Off,
    Wait,
    Issue,
    Pending
  } state_e;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic [31:0] max
  );
    return (v >= max) ? max : v + 32'd1;
  endfunction

endpackage

// File: rtl/ecc_sat_counter.sv
// Saturating event counter with synchronous clear.
// Ports: inc_i (count), clr_i (clear, an event in the same cycle wins), cnt_o.
module ecc_sat_counter
  import ecc_scrub_pkg::*;
#(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [Width-1:0] cnt_o
);

  localparam logic [31:0] Max = 32'({Width{1'b1}});

  logic [Width-1:0] r_cnt;
  logic [Width-1:0] w_nxt;

  always_comb begin
    w_nxt = r_cnt;
    if (clr_i) begin
      w_nxt = inc_i ? Width'(1) : '0;
    end else if (inc_i) begin
      w_nxt = Width'(sat_inc(32'(r_cnt), Max));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_cnt <= '0;
    else         r_cnt <= w_nxt;
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/ecc_scrub_scheduler.sv
// Scrub scheduler: bursts of scrub triggers split by idle intervals,
// address mirror, error statistics, last-error capture, irq, starvation.
// Ports: enable_i/interval_i/burst_len_i config, scrub_trigger_o and
// scrub_done_i/bit_corrected_i/uncorrectable_i scrubber handshake,
// clear_i, and busy/addr/count/err/irq/starve/sweep status outputs.
module ecc_scrub_scheduler
  import ecc_scrub_pkg::*;
#(
  parameter int unsigned DataDepth     = 2048,
  parameter int unsigned IntervalWidth = 16,
  parameter int unsigned BurstWidth    = 8,
  parameter int unsigned CntWidth      = 16,
  parameter int unsigned StarveThresh  = 1024,
  parameter int unsigned AddrWidth     = $clog2(DataDepth)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     enable_i,
  input  logic [IntervalWidth-1:0] interval_i,
  input  logic [BurstWidth-1:0]    burst_len_i,
  output logic                     scrub_trigger_o,
  input  logic                     scrub_done_i,
  input  logic                     bit_corrected_i,
  input  logic                     uncorrectable_i,
  input  logic                     clear_i,
  output logic                     busy_o,
  output logic [AddrWidth-1:0]     scrub_addr_o,
  output logic [CntWidth-1:0]      corr_cnt_o,
  output logic [CntWidth-1:0]      uncorr_cnt_o,
  output logic [AddrWidth-1:0]     err_addr_o,
  output logic                     err_valid_o,
  output logic                     irq_o,
  output logic                     starve_o,
  output logic                     sweep_done_o
);

  localparam int unsigned WaitW = $clog2(StarveThresh + 1);
  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(DataDepth - 1);
  localparam logic [WaitW-1:0] Thresh = WaitW'(StarveThresh);

  state_e                   r_state;
  state_e                   w_state_nxt;
  logic [IntervalWidth-1:0] r_int;
  logic [IntervalWidth-1:0] w_int_nxt;
  logic [BurstWidth-1:0]    r_burst;
  logic [BurstWidth-1:0]    w_burst_nxt;
  logic [BurstWidth-1:0]    w_burst_dec;
  logic [BurstWidth-1:0]    w_burst_load;
  logic [AddrWidth-1:0]     r_addr;
  logic [AddrWidth-1:0]     r_err_addr;
  logic                     r_err_valid;
  logic                     r_irq;
  logic                     r_sweep;
  logic [WaitW-1:0]         r_wait;
  logic                     w_done;
  logic                     w_corr;
  logic                     w_unc;
  logic                     w_err;
  logic                     w_outst;

  // Done pulses outside Pending belong to no trigger of ours.
  assign w_done  = scrub_done_i && (r_state == Pending);
  assign w_corr  = w_done && bit_corrected_i;
  assign w_unc   = w_done && uncorrectable_i;
  assign w_err   = w_corr || w_unc;
  assign w_outst = (r_state == Issue) || (r_state == Pending);

  assign w_burst_dec  = r_burst - BurstWidth'(1);
  assign w_burst_load = (burst_len_i == '0) ? BurstWidth'(1)
                                            : burst_len_i;

  always_comb begin
    w_state_nxt = r_state;
    w_int_nxt   = r_int;
    w_burst_nxt = r_burst;
    unique case (r_state)
      Off: begin
        if (enable_i) begin
          w_state_nxt = Wait;
          w_int_nxt   = interval_i;
        end
      end
      Wait: begin
        if (!enable_i) begin
          w_state_nxt = Off;
        end else if (r_int == '0) begin
          w_state_nxt = Issue;
          w_burst_nxt = w_burst_load;
        end else begin
          w_int_nxt = r_int - IntervalWidth'(1);
        end
      end
      Issue: begin
        w_state_nxt = Pending;
      end
      Pending: begin
        if (w_done) begin
          w_burst_nxt = w_burst_dec;
          if (!enable_i) begin
            w_state_nxt = Off;
          end else if (w_burst_dec != '0) begin
            w_state_nxt = Issue;
          end else begin
            w_state_nxt = Wait;
            w_int_nxt   = interval_i;
          end
        end
      end
      default: w_state_nxt = Off;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= Off;
      r_int   <= '0;
      r_burst <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_int   <= w_int_nxt;
      r_burst <= w_burst_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr  <= '0;
      r_sweep <= 1'b0;
    end else begin
      r_sweep <= w_done && (r_addr == LastAddr);
      if (w_done) begin
        r_addr <= (r_addr == LastAddr) ? '0
                                       : r_addr + AddrWidth'(1);
      end
    end
  end

  // Counts Issue plus Pending cycles, so Pending cycle N sees N.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wait <= '0;
    end else if (w_done || !w_outst) begin
      r_wait <= '0;
    end else if (r_wait < Thresh) begin
      r_wait <= r_wait + WaitW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err_addr  <= '0;
      r_err_valid <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      if (w_err) begin
        r_err_addr  <= r_addr;
        r_err_valid <= 1'b1;
      end else if (clear_i) begin
        r_err_addr  <= '0;
        r_err_valid <= 1'b0;
      end
      if (w_unc)        r_irq <= 1'b1;
      else if (clear_i) r_irq <= 1'b0;
    end
  end

  ecc_sat_counter #(
    .Width (CntWidth)
  ) u_corr_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (w_corr),
    .clr_i  (clear_i),
    .cnt_o  (corr_cnt_o)
  );

  ecc_sat_counter #(
    .Width (CntWidth)
  ) u_uncorr_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (w_unc),
    .clr_i  (clear_i),
    .cnt_o  (uncorr_cnt_o)
  );

  assign scrub_trigger_o = (r_state == Issue);
  assign busy_o          = w_outst;
  assign scrub_addr_o    = r_addr;
  assign err_addr_o      = r_err_addr;
  assign err_valid_o     = r_err_valid;
  assign irq_o           = r_irq;
  assign starve_o        = (r_wait >= Thresh);
  assign sweep_done_o    = r_sweep;

endmodule

// File: tb/tb_ecc_scrub_scheduler.sv
// Directed bench for ecc_scrub_scheduler (DataDepth 8, CntWidth 2).
// Inputs driven and outputs sampled on the falling clock edge.
module tb_ecc_scrub_scheduler;

  localparam int DD = 8;
  localparam int IW = 16;
  localparam int BW = 8;
  localparam int CW = 2;
  localparam int ST = 1024;
  localparam int AW = 3;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          enable_i = 1'b0;
  logic [IW-1:0] interval_i = '0;
  logic [BW-1:0] burst_len_i = '0;
  logic          scrub_trigger_o;
  logic          scrub_done_i = 1'b0;
  logic          bit_corrected_i = 1'b0;
  logic          uncorrectable_i = 1'b0;
  logic          clear_i = 1'b0;
  logic          busy_o;
  logic [AW-1:0] scrub_addr_o;
  logic [CW-1:0] corr_cnt_o;
  logic [CW-1:0] uncorr_cnt_o;
  logic [AW-1:0] err_addr_o;
  logic          err_valid_o;
  logic          irq_o;
  logic          starve_o;
  logic          sweep_done_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sweeps = 0;

  ecc_scrub_scheduler #(
    .DataDepth     (DD),
    .IntervalWidth (IW),
    .BurstWidth    (BW),
    .CntWidth      (CW),
    .StarveThresh  (ST)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .enable_i        (enable_i),
    .interval_i      (interval_i),
    .burst_len_i     (burst_len_i),
    .scrub_trigger_o (scrub_trigger_o),
    .scrub_done_i    (scrub_done_i),
    .bit_corrected_i (bit_corrected_i),
    .uncorrectable_i (uncorrectable_i),
    .clear_i         (clear_i),
    .busy_o          (busy_o),
    .scrub_addr_o    (scrub_addr_o),
    .corr_cnt_o      (corr_cnt_o),
    .uncorr_cnt_o    (uncorr_cnt_o),
    .err_addr_o      (err_addr_o),
    .err_valid_o     (err_valid_o),
    .irq_o           (irq_o),
    .starve_o        (starve_o),
    .sweep_done_o    (sweep_done_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) if (sweep_done_o) sweeps++;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, 32'({scrub_trigger_o, busy_o, scrub_addr_o,
                  corr_cnt_o, uncorr_cnt_o, err_addr_o,
                  err_valid_o, irq_o, starve_o, sweep_done_o}),
        32'd0);
  endtask

  task automatic wait_trig(input string tag, input int lim);
    int n = 0;
    while (!scrub_trigger_o && n < lim) begin
      @(negedge clk_i);
      n++;
    end
    chk({tag, "_trig"}, 32'(scrub_trigger_o), 32'd1);
  endtask

  // Waits for a trigger, checks its address, then returns done
  // in Pending cycle `pend` (1 = first Pending cycle).
  task automatic do_scrub(input string tag, input logic c,
                          input logic u, input logic clr,
                          input int pend, input int ea);
    wait_trig(tag, 64);
    chk({tag, "_addr"}, 32'(scrub_addr_o), 32'(ea));
    repeat (pend) @(negedge clk_i);
    scrub_done_i    = 1'b1;
    bit_corrected_i = c;
    uncorrectable_i = u;
    clear_i         = clr;
    @(negedge clk_i);
    scrub_done_i    = 1'b0;
    bit_corrected_i = 1'b0;
    uncorrectable_i = 1'b0;
    clear_i         = 1'b0;
  endtask

  task automatic count_trigs(input int n, output int nt);
    nt = 0;
    repeat (n) begin
      @(negedge clk_i);
      if (scrub_trigger_o) nt++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    int t0, t1, t2, t3, nt, first;

    @(negedge clk_i);
    chk_zero("reset");
    rst_ni = 1'b1;
    interval_i  = 16'd4;
    burst_len_i = 8'd2;
    @(negedge clk_i);
    enable_i = 1'b1;
    t0 = cyc;

    // Off->Wait(4,3,2,1,0)->Issue: trigger 6 edges after enable.
    wait_trig("b1", 64);
    t1 = cyc;
    chk("first_lat", 32'(t1 - t0), 32'd6);
    chk("b1_addr", 32'(scrub_addr_o), 32'd0);
    chk("b1_busy", 32'(busy_o), 32'd1);
    do_scrub("b1a", 1'b0, 1'b0, 1'b0, 2, 0);
    wait_trig("b1b", 64);
    t2 = cyc;
    chk("burst_space", 32'(t2 - t1), 32'd3);
    do_scrub("b1b", 1'b0, 1'b0, 1'b0, 2, 1);
    chk("idle_busy", 32'(busy_o), 32'd0);
    chk("idle_addr", 32'(scrub_addr_o), 32'd2);
    // 3 (trigger->done edge) + 5 Wait cycles for interval 4.
    wait_trig("b2", 64);
    t3 = cyc;
    chk("inter_space", 32'(t3 - t2), 32'd8);

    // Drop enable the cycle after the trigger.
    @(negedge clk_i);
    enable_i = 1'b0;
    @(negedge clk_i);
    scrub_done_i = 1'b1;
    @(negedge clk_i);
    scrub_done_i = 1'b0;
    chk("dis_busy", 32'(busy_o), 32'd0);
    chk("dis_addr", 32'(scrub_addr_o), 32'd3);
    count_trigs(20, nt);
    chk("dis_notrig", 32'(nt), 32'd0);

    // Statistics and error capture.
    interval_i  = 16'd0;
    burst_len_i = 8'd8;
    enable_i    = 1'b1;
    do_scrub("a3", 1'b0, 1'b0, 1'b0, 1, 3);
    do_scrub("a4", 1'b0, 1'b0, 1'b0, 1, 4);
    do_scrub("a5", 1'b1, 1'b0, 1'b0, 1, 5);
    chk("a5_corr", 32'(corr_cnt_o), 32'd1);
    chk("a5_unc", 32'(uncorr_cnt_o), 32'd0);
    chk("a5_eaddr", 32'(err_addr_o), 32'd5);
    chk("a5_evld", 32'(err_valid_o), 32'd1);
    chk("a5_irq", 32'(irq_o), 32'd0);
    do_scrub("a6", 1'b0, 1'b1, 1'b0, 1, 6);
    chk("a6_corr", 32'(corr_cnt_o), 32'd1);
    chk("a6_unc", 32'(uncorr_cnt_o), 32'd1);
    chk("a6_eaddr", 32'(err_addr_o), 32'd6);
    chk("a6_irq", 32'(irq_o), 32'd1);
    // Clear with a new uncorrectable error: new event wins.
    do_scrub("a7", 1'b0, 1'b1, 1'b1, 1, 7);
    chk("a7_corr", 32'(corr_cnt_o), 32'd0);
    chk("a7_unc", 32'(uncorr_cnt_o), 32'd1);
    chk("a7_irq", 32'(irq_o), 32'd1);
    chk("a7_evld", 32'(err_valid_o), 32'd1);
    chk("a7_eaddr", 32'(err_addr_o), 32'd7);
    chk("a7_sweep", 32'(sweep_done_o), 32'd1);
    chk("a7_wrap", 32'(scrub_addr_o), 32'd0);
    enable_i = 1'b0;
    do_scrub("a0", 1'b0, 1'b0, 1'b0, 1, 0);
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    chk("clr_corr", 32'(corr_cnt_o), 32'd0);
    chk("clr_unc", 32'(uncorr_cnt_o), 32'd0);
    chk("clr_irq", 32'(irq_o), 32'd0);
    chk("clr_evld", 32'(err_valid_o), 32'd0);
    chk("clr_eaddr", 32'(err_addr_o), 32'd0);

    // Saturation at 2'b11.
    enable_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      do_scrub("sat", 1'b1, 1'b0, 1'b0, 1, 1 + i);
      if (i == 2) chk("sat3", 32'(corr_cnt_o), 32'd3);
    end
    chk("sat5", 32'(corr_cnt_o), 32'd3);
    enable_i = 1'b0;
    do_scrub("a6b", 1'b0, 1'b0, 1'b0, 1, 6);

    // Starvation: withhold done for 1100 Pending cycles.
    burst_len_i = 8'd1;
    enable_i    = 1'b1;
    wait_trig("stv", 64);
    chk("stv_addr", 32'(scrub_addr_o), 32'd7);
    first = 0;
    nt    = 0;
    for (int k = 1; k <= 1100; k++) begin
      @(negedge clk_i);
      if (starve_o && first == 0) first = k;
      if (scrub_trigger_o) nt++;
    end
    chk("stv_rise", 32'(first), 32'd1024);
    chk("stv_notrig", 32'(nt), 32'd0);
    chk("stv_high", 32'(starve_o), 32'd1);
    scrub_done_i = 1'b1;
    @(negedge clk_i);
    scrub_done_i = 1'b0;
    enable_i     = 1'b0;
    chk("stv_fall", 32'(starve_o), 32'd0);
    chk("stv_addr2", 32'(scrub_addr_o), 32'd0);

    // Fresh sweep after reset: one wrap over eight scrubs.
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk_zero("rst2");
    @(negedge clk_i);
    rst_ni      = 1'b1;
    sweeps      = 0;
    burst_len_i = 8'd8;
    enable_i    = 1'b1;
    for (int i = 0; i < 8; i++) begin
      do_scrub("wrap", 1'b0, logic'(i == 1), 1'b0, 1, i);
    end
    @(negedge clk_i);
    chk("wrap_cnt", 32'(sweeps), 32'd1);
    chk("wrap_addr", 32'(scrub_addr_o), 32'd0);
    chk("wrap_irq", 32'(irq_o), 32'd1);
    chk("wrap_unc", 32'(uncorr_cnt_o), 32'd1);

    // Reset in the middle of Pending.
    wait_trig("rmid", 64);
    @(negedge clk_i);
    chk("rmid_busy", 32'(busy_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk_zero("rmid");
    @(negedge clk_i);
    rst_ni   = 1'b1;
    enable_i = 1'b0;
    count_trigs(10, nt);
    chk("rmid_notrig", 32'(nt), 32'd0);
    chk("rmid_addr", 32'(scrub_addr_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
